// File: rtl/rv32i_branch_pred.sv
// rv32i_branch_pred: IF-stage branch predictor with a direct-mapped BTB, a local
// PHT, a gshare-style global PHT and a local/global chooser.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_strategy              prediction mode: 00 NONE, 01 LOC, 10 GLB, 11 BOTH
//   i_if_pc                 fetch PC, looked up combinationally
//   o_pred_pc               predicted next PC
//   o_is_pred_taken         final taken prediction
//   o_is_pred_hit           BTB hit (valid and tag match)
//   o_is_glb_taken          raw global PHT counter MSB
//   o_is_loc_taken          raw local PHT counter MSB
//   i_ex_*                  resolved control-flow instruction from EX (training)
//   o_br_total, o_br_miss   saturating resolved / mispredicted counts
module rv32i_branch_pred #(
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned GHR_W     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_strategy,
  input  logic [31:0] i_if_pc,
  output logic [31:0] o_pred_pc,
  output logic        o_is_pred_taken,
  output logic        o_is_pred_hit,
  output logic        o_is_glb_taken,
  output logic        o_is_loc_taken,
  input  logic        i_ex_upd_vld,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jp,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_is_glb_taken,
  input  logic        i_ex_is_loc_taken,
  input  logic        i_ex_pred_wrong,
  output logic [31:0] o_br_total,
  output logic [31:0] o_br_miss
);

  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned PHT_N = 1 << PHT_IDX_W;
  localparam int unsigned TAG_W = 30 - BTB_IDX_W;

  typedef enum logic [1:0] {
    STRAT_NONE = 2'b00,
    STRAT_LOC  = 2'b01,
    STRAT_GLB  = 2'b10,
    STRAT_BOTH = 2'b11
  } pre_strategy_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_jp;
  } btb_entry_t;

  btb_entry_t       btb_q     [BTB_N];
  logic [1:0]       loc_pht_q [PHT_N];
  logic [1:0]       glb_pht_q [PHT_N];
  logic [1:0]       chooser_q [PHT_N];
  logic [GHR_W-1:0] ghr_q;
  logic [31:0]      br_total_q;
  logic [31:0]      br_miss_q;

  // Saturating 2-bit counter step toward 'up'.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  // Lookup-side indices.
  logic [BTB_IDX_W-1:0] if_btb_idx;
  logic [TAG_W-1:0]     if_tag;
  logic [PHT_IDX_W-1:0] if_loc_idx;
  logic [PHT_IDX_W-1:0] if_glb_idx;

  assign if_btb_idx = i_if_pc[BTB_IDX_W+1:2];
  assign if_tag     = i_if_pc[31:BTB_IDX_W+2];
  assign if_loc_idx = i_if_pc[PHT_IDX_W+1:2];
  assign if_glb_idx = if_loc_idx ^ PHT_IDX_W'(ghr_q);

  // Update-side indices; the global index uses the GHR before this edge.
  logic [BTB_IDX_W-1:0] ex_btb_idx;
  logic [TAG_W-1:0]     ex_tag;
  logic [PHT_IDX_W-1:0] ex_loc_idx;
  logic [PHT_IDX_W-1:0] ex_glb_idx;
  logic                 upd;
  logic                 upd_br;

  assign ex_btb_idx = i_ex_pc[BTB_IDX_W+1:2];
  assign ex_tag     = i_ex_pc[31:BTB_IDX_W+2];
  assign ex_loc_idx = i_ex_pc[PHT_IDX_W+1:2];
  assign ex_glb_idx = ex_loc_idx ^ PHT_IDX_W'(ghr_q);
  assign upd        = i_ex_upd_vld & (i_ex_is_br | i_ex_is_jp);
  assign upd_br     = upd & i_ex_is_br;

  // PC bits [1:0] never index anything (instructions are word aligned).
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{i_if_pc[1:0], i_ex_pc[1:0]};

  // Combinational lookup and direction select.
  btb_entry_t    rd_entry;
  pre_strategy_e strategy;
  logic          hit;
  logic          loc_t;
  logic          glb_t;
  logic          use_glb;
  logic          taken;

  always_comb begin
    rd_entry = btb_q[if_btb_idx];
    strategy = pre_strategy_e'(i_strategy);
    hit      = rd_entry.valid & (rd_entry.tag == if_tag);
    loc_t    = loc_pht_q[if_loc_idx][1];
    glb_t    = glb_pht_q[if_glb_idx][1];
    use_glb  = chooser_q[if_loc_idx][1];
    taken    = 1'b0;
    if (hit) begin
      if (rd_entry.is_jp) begin
        taken = 1'b1;
      end else begin
        unique case (strategy)
          STRAT_NONE: taken = 1'b1;
          STRAT_LOC:  taken = loc_t;
          STRAT_GLB:  taken = glb_t;
          STRAT_BOTH: taken = use_glb ? glb_t : loc_t;
          default:    taken = 1'b0;
        endcase
      end
    end
  end

  assign o_pred_pc       = taken ? rd_entry.target : i_if_pc + 32'd4;
  assign o_is_pred_taken = taken;
  assign o_is_pred_hit   = hit;
  assign o_is_glb_taken  = glb_t;
  assign o_is_loc_taken  = loc_t;
  assign o_br_total      = br_total_q;
  assign o_br_miss       = br_miss_q;

  // BTB: only taken control flow allocates or refreshes an entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BTB_N); i++) btb_q[i] <= '0;
    end else if (upd && i_ex_taken) begin
      btb_q[ex_btb_idx] <= '{valid:  1'b1,
                             tag:    ex_tag,
                             target: i_ex_target,
                             is_jp:  i_ex_is_jp};
    end
  end

  // Direction tables and global history train on conditional branches only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(PHT_N); i++) begin
        loc_pht_q[i] <= 2'b01;
        glb_pht_q[i] <= 2'b01;
        chooser_q[i] <= 2'b01;
      end
      ghr_q <= '0;
    end else if (upd_br) begin
      loc_pht_q[ex_loc_idx] <= sat_step(loc_pht_q[ex_loc_idx], i_ex_taken);
      glb_pht_q[ex_glb_idx] <= sat_step(glb_pht_q[ex_glb_idx], i_ex_taken);
      // Chooser moves only when the two predictors disagreed.
      if (i_ex_is_glb_taken != i_ex_is_loc_taken) begin
        chooser_q[ex_loc_idx] <= sat_step(chooser_q[ex_loc_idx],
                                          i_ex_is_glb_taken == i_ex_taken);
      end
      ghr_q <= GHR_W'({ghr_q, i_ex_taken});
    end
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_total_q <= '0;
      br_miss_q  <= '0;
    end else if (upd) begin
      if (br_total_q != 32'hFFFF_FFFF) br_total_q <= br_total_q + 32'd1;
      if (i_ex_pred_wrong && (br_miss_q != 32'hFFFF_FFFF)) br_miss_q <= br_miss_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_branch_pred.sv
// Directed self-checking bench for rv32i_branch_pred.
module tb_rv32i_branch_pred;

  logic        clk;
  logic        rst;
  logic [1:0]  strategy;
  logic [31:0] if_pc;
  logic [31:0] pred_pc;
  logic        is_pred_taken;
  logic        is_pred_hit;
  logic        is_glb_taken;
  logic        is_loc_taken;
  logic        ex_upd_vld;
  logic [31:0] ex_pc;
  logic        ex_is_br;
  logic        ex_is_jp;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_is_glb_taken;
  logic        ex_is_loc_taken;
  logic        ex_pred_wrong;
  logic [31:0] br_total;
  logic [31:0] br_miss;

  int n_tests;
  int n_fail;

  rv32i_branch_pred dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_strategy        (strategy),
    .i_if_pc           (if_pc),
    .o_pred_pc         (pred_pc),
    .o_is_pred_taken   (is_pred_taken),
    .o_is_pred_hit     (is_pred_hit),
    .o_is_glb_taken    (is_glb_taken),
    .o_is_loc_taken    (is_loc_taken),
    .i_ex_upd_vld      (ex_upd_vld),
    .i_ex_pc           (ex_pc),
    .i_ex_is_br        (ex_is_br),
    .i_ex_is_jp        (ex_is_jp),
    .i_ex_taken        (ex_taken),
    .i_ex_target       (ex_target),
    .i_ex_is_glb_taken (ex_is_glb_taken),
    .i_ex_is_loc_taken (ex_is_loc_taken),
    .i_ex_pred_wrong   (ex_pred_wrong),
    .o_br_total        (br_total),
    .o_br_miss         (br_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one resolved EX instruction for exactly one clock edge.
  task automatic ex_update(input logic [31:0] pc, input logic br, input logic jp,
                           input logic tk, input logic [31:0] tgt,
                           input logic glb, input logic loc, input logic wrong);
    @(negedge clk);
    ex_pc           = pc;
    ex_is_br        = br;
    ex_is_jp        = jp;
    ex_taken        = tk;
    ex_target       = tgt;
    ex_is_glb_taken = glb;
    ex_is_loc_taken = loc;
    ex_pred_wrong   = wrong;
    ex_upd_vld      = 1'b1;
    @(posedge clk);
    #1;
    ex_upd_vld = 1'b0;
  endtask

  // Present a fetch PC and mode, then let the combinational lookup settle.
  task automatic lookup(input logic [31:0] pc, input logic [1:0] strat);
    if_pc    = pc;
    strategy = strat;
    #1;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b1;
    strategy        = 2'b00;
    if_pc           = 32'h0;
    ex_upd_vld      = 1'b0;
    ex_pc           = 32'h0;
    ex_is_br        = 1'b0;
    ex_is_jp        = 1'b0;
    ex_taken        = 1'b0;
    ex_target       = 32'h0;
    ex_is_glb_taken = 1'b0;
    ex_is_loc_taken = 1'b0;
    ex_pred_wrong   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset: every mode misses and falls through to pc+4.
    for (int s = 0; s < 4; s++) begin
      lookup(32'h100, 2'(s));
      check($sformatf("rst_hit_s%0d", s),   32'(is_pred_hit),   32'd0);
      check($sformatf("rst_taken_s%0d", s), 32'(is_pred_taken), 32'd0);
      check($sformatf("rst_pc_s%0d", s),    pred_pc,            32'h104);
      check($sformatf("rst_loc_s%0d", s),   32'(is_loc_taken),  32'd0);
      check($sformatf("rst_glb_s%0d", s),   32'(is_glb_taken),  32'd0);
    end
    check("rst_total", br_total, 32'd0);
    check("rst_miss",  br_miss,  32'd0);

    // Taken branch 0x100 -> 0x80: local[0x40] 01->10, GHR=1.
    ex_update(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 2'b01);
    check("loc1_hit",   32'(is_pred_hit),   32'd1);
    check("loc1_loc",   32'(is_loc_taken),  32'd1);
    check("loc1_glb",   32'(is_glb_taken),  32'd0);
    check("loc1_taken", 32'(is_pred_taken), 32'd1);
    check("loc1_pc",    pred_pc,            32'h80);
    check("loc1_total", br_total,           32'd1);
    lookup(32'h100, 2'b11);
    check("both_init_taken", 32'(is_pred_taken), 32'd1);
    lookup(32'h100, 2'b10);
    check("glb1_taken", 32'(is_pred_taken), 32'd0);
    check("glb1_pc",    pred_pc,            32'h104);
    lookup(32'h104, 2'b00);
    check("none_miss_pc", pred_pc, 32'h108);

    // Two not-taken: local 10->01->00; BTB entry stays.
    ex_update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    ex_update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 2'b01);
    check("nt2_hit",   32'(is_pred_hit),   32'd1);
    check("nt2_taken", 32'(is_pred_taken), 32'd0);
    check("nt2_pc",    pred_pc,            32'h104);
    lookup(32'h100, 2'b00);
    check("nt2_none_pc", pred_pc, 32'h80);
    // Two more not-taken saturate at 00; GHR ends at 0x10.
    ex_update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    ex_update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 2'b01);
    check("nt4_loc",   32'(is_loc_taken),  32'd0);
    check("nt4_taken", 32'(is_pred_taken), 32'd0);
    check("nt4_total", br_total,           32'd5);

    // JAL 0x200 -> 0x400 under GLB.
    ex_update(32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    lookup(32'h200, 2'b10);
    check("jal_hit",   32'(is_pred_hit),   32'd1);
    check("jal_taken", 32'(is_pred_taken), 32'd1);
    check("jal_pc",    pred_pc,            32'h400);
    check("jal_total", br_total,           32'd6);
    // pc 0x140 -> idx 0x50; with GHR still 0x10 it reads global[0x40]=10.
    lookup(32'h140, 2'b10);
    check("jal_ghr_glb", 32'(is_glb_taken),  32'd1);
    check("jal_ghr_pc",  pred_pc,            32'h144);

    // Chooser training at 0x600 (idx 0x80): glb right, loc wrong.
    ex_update(32'h600, 1'b1, 1'b0, 1'b1, 32'h700, 1'b1, 1'b0, 1'b1);
    check("ch1_miss",  br_miss,  32'd1);
    check("ch1_total", br_total, 32'd7);
    lookup(32'h600, 2'b01);
    check("ch1_loc_taken", 32'(is_pred_taken), 32'd1);
    check("ch1_loc_pc",    pred_pc,            32'h700);
    // GHR=0x21 -> global[0xA1]=01, chooser 10 selects glb.
    lookup(32'h600, 2'b11);
    check("ch1_both_glb",   32'(is_glb_taken),  32'd0);
    check("ch1_both_taken", 32'(is_pred_taken), 32'd0);
    check("ch1_both_pc",    pred_pc,            32'h604);
    ex_update(32'h600, 1'b1, 1'b0, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    lookup(32'h600, 2'b11);
    check("ch2_both_taken", 32'(is_pred_taken), 32'd0);
    check("ch2_miss",       br_miss,            32'd1);
    check("ch2_total",      br_total,           32'd8);

    // Same-cycle lookup and first taken update of 0x300.
    @(negedge clk);
    ex_pc           = 32'h300;
    ex_is_br        = 1'b1;
    ex_is_jp        = 1'b0;
    ex_taken        = 1'b1;
    ex_target       = 32'h380;
    ex_is_glb_taken = 1'b0;
    ex_is_loc_taken = 1'b0;
    ex_pred_wrong   = 1'b0;
    ex_upd_vld      = 1'b1;
    lookup(32'h300, 2'b00);
    check("same_hit", 32'(is_pred_hit), 32'd0);
    check("same_pc",  pred_pc,          32'h304);
    @(posedge clk);
    #1;
    ex_upd_vld = 1'b0;
    #1;
    check("next_hit", 32'(is_pred_hit),   32'd1);
    check("next_tk",  32'(is_pred_taken), 32'd1);
    check("next_pc",  pred_pc,            32'h380);

    // Reset wins over a same-cycle update.
    @(negedge clk);
    rst        = 1'b1;
    ex_pc      = 32'h800;
    ex_target  = 32'h900;
    ex_upd_vld = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    ex_upd_vld = 1'b0;
    lookup(32'h800, 2'b00);
    check("rstupd_hit",   32'(is_pred_hit), 32'd0);
    check("rstupd_pc",    pred_pc,          32'h804);
    lookup(32'h100, 2'b01);
    check("rstupd_hit100", 32'(is_pred_hit),  32'd0);
    check("rstupd_loc",    32'(is_loc_taken), 32'd0);
    check("rstupd_total",  br_total,          32'd0);
    check("rstupd_miss",   br_miss,           32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
